fastram_burst_ctrl: RTL

//  Parametrised 68030 synchronous-termination controller for on-board fast RAM.

---
 rtl/fastram_burst_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fastram_burst_ctrl.sv
// 68030 fast-RAM controller: decodes the configured window, drives per-bank byte-lane
// chip selects and terminates with STERM, including 4-beat cache-line bursts.
module fastram_burst_ctrl #(
    parameter int BANKS      = 4,
    parameter int BANK_LSB   = 21,
    parameter int BASE_LSB   = 23,
    parameter int WAIT_FIRST = 1,
    parameter int WAIT_BURST = 0,
    parameter int BURST_EN   = 1
) (
    input  logic                  CLKCPU,
    input  logic                  RESET,
    input  logic [23:0]           A,
    input  logic [1:0]            SIZ,
    input  logic                  AS20,
    input  logic                  DS20,
    input  logic                  RW20,
    input  logic                  CBREQ,
    input  logic [23-BASE_LSB:0]  BASE,
    input  logic                  CONFIGURED,
    output logic                  STERM,
    output logic                  CBACK,
    output logic                  CIIN,
    output logic                  INTCYCLE,
    output logic [4*BANKS-1:0]    RAMCS,
    output logic                  RAMOE,
    output logic [1:0]            BURST_A
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_TERM = 3'd2;
    localparam logic [2:0] S_BEAT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_reg, state_next;
    logic [2:0]         wait_cnt_reg, wait_cnt_next;
    logic [1:0]         beat_reg, beat_next;
    logic [1:0]         burst_a_reg, burst_a_next;
    logic               sterm_reg, sterm_next;
    logic               cback_reg, cback_next;
    logic               rd_reg, rd_next;
    logic               burst_reg, burst_next;
    logic               as_low_reg;
    logic               intcycle_reg, ramoe_reg;
    logic [4*BANKS-1:0] ramcs_reg, ramcs_next;

    logic               hit, burst_start, pulse, active_next;
    logic [2:0]         len, lim;
    logic [3:0]         size_lanes, lanes_next;
    logic [BANK_W-1:0]  bank_sel;

    // as_low_reg blocks a late hit: only the first edge of a strobe is decoded
    assign hit = CONFIGURED & ~AS20 & ~as_low_reg & (A[23:BASE_LSB] == BASE);
    assign burst_start = (BURST_EN != 0) & ~CBREQ & (SIZ == 2'b00) & (A[1:0] == 2'b00);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_next     = beat_reg;
        burst_a_next  = burst_a_reg;
        cback_next    = cback_reg;
        rd_next       = rd_reg;
        burst_next    = burst_reg;
        sterm_next    = 1'b1;
        pulse         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (hit) begin
                    burst_a_next = A[3:2];
                    beat_next    = 2'd0;
                    cback_next   = ~burst_start;
                    burst_next   = burst_start;
                    rd_next      = RW20;
                    if (WAIT_FIRST == 0) begin
                        state_next = S_TERM;
                        sterm_next = 1'b0;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = 3'(WAIT_FIRST - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_reg == 3'd0) begin
                    state_next = S_TERM;
                    sterm_next = 1'b0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end
            end
            S_TERM, S_BEAT: begin
                // sterm_reg low means a beat was just terminated
                if (!sterm_reg) begin
                    if (cback_reg) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_BEAT;
                        if (WAIT_BURST == 0)
                            pulse = 1'b1;
                        else
                            wait_cnt_next = 3'(WAIT_BURST - 1);
                    end
                end else if (wait_cnt_reg == 3'd0) begin
                    pulse = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end
            end
            default: ;
        endcase
        if (pulse) begin
            sterm_next   = 1'b0;
            burst_a_next = burst_a_reg + 2'd1;
            beat_next    = beat_reg + 2'd1;
            // last beat, or the CPU withdrew its request: release CBACK with this STERM
            cback_next   = (beat_reg == 2'd2) | CBREQ;
        end
        if (state_reg != S_IDLE && AS20) begin
            state_next = S_IDLE;
            sterm_next = 1'b1;
            cback_next = 1'b1;
        end
    end

    assign active_next = (state_next != S_IDLE);
    assign len = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
    assign lim = {1'b0, A[1:0]} + len;
    assign bank_sel = (BANKS > 1) ? A[BANK_LSB +: BANK_W] : '0;

    // byte offset k lands on lane bit 3-k (offset 0 is D31:24)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign size_lanes[3-gi] = (3'(gi) >= {1'b0, A[1:0]}) && (3'(gi) < lim);
        end
    endgenerate

    assign lanes_next = (rd_next | burst_next) ? 4'hF : (DS20 ? 4'h0 : size_lanes);

    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
            assign ramcs_next[4*gi +: 4] =
                (active_next && bank_sel == BANK_W'(gi)) ? ~lanes_next : 4'hF;
        end
    endgenerate

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 3'd0;
            beat_reg     <= 2'd0;
            burst_a_reg  <= 2'd0;
            sterm_reg    <= 1'b1;
            cback_reg    <= 1'b1;
            rd_reg       <= 1'b0;
            burst_reg    <= 1'b0;
            as_low_reg   <= 1'b0;
            intcycle_reg <= 1'b1;
            ramoe_reg    <= 1'b1;
            ramcs_reg    <= '1;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_reg     <= beat_next;
            burst_a_reg  <= burst_a_next;
            sterm_reg    <= sterm_next;
            cback_reg    <= cback_next;
            rd_reg       <= rd_next;
            burst_reg    <= burst_next;
            as_low_reg   <= ~AS20;
            intcycle_reg <= ~active_next;
            ramoe_reg    <= ~(active_next & rd_next);
            ramcs_reg    <= ramcs_next;
        end
    end

    assign STERM    = sterm_reg;
    assign CBACK    = cback_reg;
    assign CIIN     = 1'b1;
    assign INTCYCLE = intcycle_reg;
    assign RAMOE    = ramoe_reg;
    assign RAMCS    = ramcs_reg;
    assign BURST_A  = (state_reg == S_IDLE) ? A[3:2] : burst_a_reg;
endmodule
